// File: rtl/keypad_scan_rx.sv
// 4x4 matrix keypad scanner with debounce and a one-entry valid/ready key register.
// Optional auto-repeat of a held key is compiled in when KEYPAD_REPEAT_EN is defined.
module keypad_scan_rx #(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_SCANS = 10,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_t;

  logic [3:0]    row_s1, row_s2;
  logic [TW-1:0] tick;
  logic [1:0]    col;
  logic          slot_end, scan_done;
  logic [3:0]    rows_low;
  logic          slot_any, slot_one;
  logic [1:0]    slot_row;
  logic          acc_hit, acc_multi;
  logic [3:0]    acc_key;
  logic          merge_hit, merge_multi;
  logic [3:0]    merge_key;
  logic          res_none, res_one;
  state_t        state, state_nx;
  logic [DW-1:0] cnt, cnt_nx, cnt_inc;
  logic [3:0]    cand, cand_nx, emit_code;
  logic          emit;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_map = 4'h1;
      4'b00_01: key_map = 4'h2;
      4'b00_10: key_map = 4'h3;
      4'b00_11: key_map = 4'hA;
      4'b01_00: key_map = 4'h4;
      4'b01_01: key_map = 4'h5;
      4'b01_10: key_map = 4'h6;
      4'b01_11: key_map = 4'hB;
      4'b10_00: key_map = 4'h7;
      4'b10_01: key_map = 4'h8;
      4'b10_10: key_map = 4'h9;
      4'b10_11: key_map = 4'hC;
      4'b11_00: key_map = 4'hE;
      4'b11_01: key_map = 4'h0;
      4'b11_10: key_map = 4'hF;
      default:  key_map = 4'hD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
      tick   <= '0;
      col    <= 2'd0;
      col_n  <= 4'b1110;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
      if (slot_end) begin
        tick  <= '0;
        col   <= col + 2'd1;
        col_n <= {col_n[2:0], col_n[3]};
      end else begin
        tick <= tick + TW'(1);
      end
    end
  end

  assign slot_end  = (tick == TICK_LAST);
  assign scan_done = slot_end && (col == 2'd3);
  assign rows_low  = ~row_s2;
  assign slot_any  = |rows_low;
  assign slot_one  = slot_any && ((rows_low & (rows_low - 4'd1)) == 4'd0);

  always_comb begin
    slot_row = 2'd0;
    case (rows_low)
      4'b0010: slot_row = 2'd1;
      4'b0100: slot_row = 2'd2;
      4'b1000: slot_row = 2'd3;
      default: slot_row = 2'd0;
    endcase
  end

  // Fold the current slot into the running scan so the result is ready on the last tick.
  assign merge_hit   = acc_hit || slot_any;
  assign merge_multi = acc_multi || (slot_any && (!slot_one || acc_hit));
  assign merge_key   = (slot_one && !acc_hit) ? key_map(slot_row, col) : acc_key;
  assign res_none    = !merge_hit;
  assign res_one     = merge_hit && !merge_multi;

  always_ff @(posedge clk) begin
    if (rst || scan_done) begin
      acc_hit   <= 1'b0;
      acc_multi <= 1'b0;
      acc_key   <= 4'h0;
    end else if (slot_end) begin
      acc_hit   <= merge_hit;
      acc_multi <= merge_multi;
      acc_key   <= merge_key;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep, rep_nx;

  always_ff @(posedge clk) begin
    if (rst) rep <= '0;
    else     rep <= rep_nx;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= 4'h0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
    end
  end

  assign cnt_inc = cnt + DW'(1);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    cand_nx   = cand;
    emit      = 1'b0;
    emit_code = cand;
`ifdef KEYPAD_REPEAT_EN
    rep_nx    = rep;
`endif
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (res_one) begin
            cand_nx   = merge_key;
            emit_code = merge_key;
            if (DEBOUNCE_SCANS == 1) begin
              emit     = 1'b1;
              state_nx = HELD;
            end else begin
              cnt_nx   = DW'(1);
              state_nx = PRESS_DEB;
            end
          end
        end
        PRESS_DEB: begin
          if (res_one && (merge_key == cand)) begin
            if (cnt_inc == DEB_LAST) begin
              emit     = 1'b1;
              state_nx = HELD;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            state_nx = IDLE;
          end
        end
        HELD: begin
          if (res_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_nx = IDLE;
            end else begin
              cnt_nx   = DW'(1);
              state_nx = REL_DEB;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else if (res_one && (merge_key == cand)) begin
            if (rep + RW'(1) == REP_LAST) begin
              emit   = 1'b1;
              rep_nx = '0;
            end else begin
              rep_nx = rep + RW'(1);
            end
          end
`endif
        end
        default: begin
          if (res_none) begin
            if (cnt_inc == DEB_LAST) state_nx = IDLE;
            else                     cnt_nx   = cnt_inc;
          end else begin
            state_nx = HELD;
          end
        end
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if (state_nx != HELD) rep_nx = '0;
`endif
  end

  assign key_held = (state == HELD) || (state == REL_DEB);

  // A full register only takes a new code when it is being drained on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (emit) begin
      if (!key_valid || key_ready) begin
        key_code  <= emit_code;
        key_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_rx.sv
// Directed testbench for keypad_scan_rx with SCAN_TICKS=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=2.
// Models the keypad as a 16-bit pressed mask (bit r*4+c) wired through the column drive.
module tb_keypad_scan_rx;

  logic       clk;
  logic       rst;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overflow;

  logic [15:0] pressed;
  int          checkCount;
  int          errorCount;
  int          xferCount;
  logic [3:0]  lastXfer;
  int          xferBase;

`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_XFERS = 4;
`else
  localparam int HOLD_XFERS = 1;
`endif

  localparam logic [15:0] K1 = 16'h0001;
  localparam logic [15:0] KA = 16'h0008;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] K6 = 16'h0040;
  localparam logic [15:0] KC = 16'h0800;
  localparam logic [15:0] K0 = 16'h2000;
  localparam logic [15:0] KF = 16'h4000;

  keypad_scan_rx #(
    .SCAN_TICKS(4),
    .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row_n(row_n),
    .col_n(col_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held(key_held),
    .overflow(overflow)
  );

  assign row_n[0] = ~|(pressed[3:0]   & ~col_n);
  assign row_n[1] = ~|(pressed[7:4]   & ~col_n);
  assign row_n[2] = ~|(pressed[11:8]  & ~col_n);
  assign row_n[3] = ~|(pressed[15:12] & ~col_n);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every accepted handshake is logged so held-key emissions can be counted.
  always @(posedge clk) begin
    if (!rst && key_valid && key_ready) begin
      xferCount = xferCount + 1;
      lastXfer  = key_code;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (observed !== expected) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Returns on the falling edge just after column 0 is driven again.
  task automatic waitScanStart();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = col_n;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && col_n == 4'b1110) found = 1'b1;
      prev = col_n;
    end
    if (!found) checkOutput("scan_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input int scans);
    pressed = keys;
    for (int i = 0; i < scans; i++) waitScanStart();
  endtask

  task automatic pulseReady();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  logic [3:0] colExp [4];

  initial begin
    checkCount = 0;
    errorCount = 0;
    xferCount  = 0;
    lastXfer   = 4'h0;
    pressed    = 16'h0;
    key_ready  = 1'b0;
    rst        = 1'b1;
    colExp     = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    repeat (2) @(negedge clk);
    checkOutput("rst_col", col_n, 4'b1110);
    checkOutput("rst_valid", key_valid, 1'b0);
    checkOutput("rst_overflow", overflow, 1'b0);
    checkOutput("rst_held", key_held, 1'b0);
    checkOutput("rst_code", key_code, 4'h0);
    rst = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("col0_hold", col_n, 4'b1110);
    @(negedge clk);
    checkOutput("col_step0", col_n, colExp[0]);
    for (int i = 1; i < 4; i++) begin
      repeat (4) @(negedge clk);
      checkOutput("col_step", col_n, colExp[i]);
    end

    // '6' bounces for one scan, then is stable for three
    applyStimulus(K6, 1);
    applyStimulus(16'h0, 1);
    applyStimulus(K6, 2);
    checkOutput("six_early_valid", key_valid, 1'b0);
    checkOutput("six_early_held", key_held, 1'b0);
    applyStimulus(K6, 1);
    checkOutput("six_valid", key_valid, 1'b1);
    checkOutput("six_code", key_code, 4'h6);
    checkOutput("six_held", key_held, 1'b1);
    applyStimulus(16'h0, 2);
    checkOutput("six_rel_held", key_held, 1'b1);
    applyStimulus(16'h0, 1);
    checkOutput("six_released", key_held, 1'b0);
    pulseReady();
    checkOutput("six_drained", key_valid, 1'b0);
    checkOutput("six_code_kept", key_code, 4'h6);
    checkOutput("six_xfer", lastXfer, 4'h6);
    waitScanStart();

    // '0' held for ten scans with the consumer always ready
    xferBase  = xferCount;
    key_ready = 1'b1;
    applyStimulus(K0, 10);
    applyStimulus(16'h0, 3);
    key_ready = 1'b0;
    checkOutput("zero_xfers", xferCount - xferBase, HOLD_XFERS);
    checkOutput("zero_code", lastXfer, 4'h0);
    checkOutput("zero_valid", key_valid, 1'b0);
    checkOutput("zero_held", key_held, 1'b0);

    // 'A' then '5' with nobody draining: '5' is dropped
    checkOutput("pre_overflow", overflow, 1'b0);
    applyStimulus(KA, 3);
    checkOutput("a_valid", key_valid, 1'b1);
    checkOutput("a_code", key_code, 4'hA);
    applyStimulus(16'h0, 3);
    applyStimulus(K5, 3);
    checkOutput("ovf_set", overflow, 1'b1);
    checkOutput("ovf_code", key_code, 4'hA);
    checkOutput("ovf_valid", key_valid, 1'b1);
    pulseReady();
    checkOutput("ovf_drained", key_valid, 1'b0);
    checkOutput("ovf_sticky", overflow, 1'b1);
    waitScanStart();
    applyStimulus(16'h0, 3);

    // two keys from idle, then '1' with 'C' added while held
    applyStimulus(K1 | KC, 4);
    checkOutput("multi_valid", key_valid, 1'b0);
    checkOutput("multi_held", key_held, 1'b0);
    applyStimulus(16'h0, 1);
    xferBase  = xferCount;
    key_ready = 1'b1;
    applyStimulus(K1, 3);
    checkOutput("one_held", key_held, 1'b1);
    checkOutput("one_code", key_code, 4'h1);
    applyStimulus(K1 | KC, 3);
    checkOutput("second_held", key_held, 1'b1);
    applyStimulus(16'h0, 3);
    key_ready = 1'b0;
    checkOutput("second_xfers", xferCount - xferBase, 1);
    checkOutput("second_last", lastXfer, 4'h1);

    // reset two scans into debouncing 'F'
    applyStimulus(KF, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid_rst_col", col_n, 4'b1110);
    checkOutput("mid_rst_valid", key_valid, 1'b0);
    checkOutput("mid_rst_code", key_code, 4'h0);
    checkOutput("mid_rst_held", key_held, 1'b0);
    checkOutput("mid_rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    waitScanStart();
    waitScanStart();
    checkOutput("f_early_valid", key_valid, 1'b0);
    checkOutput("f_early_held", key_held, 1'b0);
    waitScanStart();
    checkOutput("f_valid", key_valid, 1'b1);
    checkOutput("f_code", key_code, 4'hF);
    checkOutput("f_held", key_held, 1'b1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
